// File: rtl/weights_pkg.sv
// Shared types and byte geometry for the weight stream unpacker.
package weights_pkg;

    localparam int WSU_IN_BYTES  = 8;
    localparam int WSU_OUT_BYTES = 9;
    localparam int WSU_BUF_BYTES = 16;

    typedef enum logic [1:0] {
        WSU_IDLE = 2'd0,
        WSU_LOAD = 2'd1,
        WSU_WAIT = 2'd2,
        WSU_DONE = 2'd3
    } wsu_state_t;

endpackage

// File: rtl/weight_stream_unpacker_if.sv
// Weight byte stream (in) plus weight-manager write port (out) of the unpacker.
interface weight_stream_unpacker_if #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 72
);
    logic [IN_W-1:0]  s_tdata;
    logic             s_tvalid;
    logic             s_tlast;
    logic             s_tready;
    logic             wm_write_mode;
    logic             wm_data_valid;
    logic [OUT_W-1:0] wm_data_out;
    logic             wm_write_complete;

    modport master (
        output s_tdata, s_tvalid, s_tlast, wm_write_complete,
        input  s_tready, wm_write_mode, wm_data_valid, wm_data_out
    );

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, wm_write_complete,
        output s_tready, wm_write_mode, wm_data_valid, wm_data_out
    );
endinterface

// File: rtl/byte_gearbox_8to9.sv
// 16-byte repacking buffer: 8-byte beats in, 9-byte words out, oldest byte at [7:0].
module byte_gearbox_8to9
    import weights_pkg::*;
#(
    parameter int IN_W  = 64,
    parameter int OUT_W = 72
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic             emit_en,
    output logic             emit,
    output logic [OUT_W-1:0] out_data
);
    localparam int BUF_W = WSU_BUF_BYTES * 8;
    localparam logic [4:0] OUT_B = 5'(WSU_OUT_BYTES);
    localparam logic [4:0] IN_B  = 5'(WSU_IN_BYTES);

    logic [BUF_W-1:0] buf_q, buf_d, shifted;
    logic [4:0]       fill_q, fill_d, remaining;

    // Bytes above fill are kept zero, so a new beat can be OR-ed in at the fill point.
    always_comb begin
        emit      = emit_en && (fill_q >= OUT_B);
        shifted   = emit ? (buf_q >> OUT_W) : buf_q;
        remaining = emit ? (fill_q - OUT_B) : fill_q;
        buf_d     = shifted;
        fill_d    = remaining;
        if (in_valid) begin
            buf_d  = shifted | (BUF_W'(in_data) << {remaining, 3'b000});
            fill_d = remaining + IN_B;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
        end
    end

    assign out_data = buf_q[OUT_W-1:0];
endmodule

// File: rtl/weight_stream_unpacker.sv
// Unpacks a 64-bit weight stream into 72-bit 3x3 kernel words for the weight manager.
// Optional: define WSU_TLAST_CHECK_EN to flag s_tlast placement errors.
module weight_stream_unpacker
    import weights_pkg::*;
#(
    parameter int IN_W  = 64,
    parameter int OUT_W = 72
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [9:0]              cfg_ci_groups,
    input  logic [9:0]              cfg_co_groups,
    weight_stream_unpacker_if.slave bus,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    wsu_state_t  state_q, state_d;
    logic [9:0]  ci_q, co_q;
    logic [19:0] grp_prod;
    logic [26:0] beats_exp, beats_acc;
    logic [25:0] words_exp, words_cnt;
    logic        start_acc, cfg_zero, accept, emit, emit_en, last_word, err_d;

    // 72 = 64 + 8, 64 = 1 << 6
    assign grp_prod  = ci_q * co_q;
    assign words_exp = {grp_prod, 6'b000000};
    assign beats_exp = 27'({grp_prod, 6'b000000}) + 27'({grp_prod, 3'b000});

    assign cfg_zero  = (cfg_ci_groups == '0) || (cfg_co_groups == '0);
    assign start_acc = start && (state_q == WSU_IDLE);
    assign accept    = bus.s_tvalid && bus.s_tready;
    assign last_word = emit && (words_cnt == words_exp - 26'd1);

    always_ff @(posedge clk) begin
        if (rst) state_q <= WSU_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WSU_IDLE: if (start_acc) state_d = cfg_zero ? WSU_DONE : WSU_LOAD;
            WSU_LOAD: if (last_word) state_d = WSU_WAIT;
            WSU_WAIT: if (bus.wm_write_complete) state_d = WSU_DONE;
            WSU_DONE: state_d = WSU_IDLE;
            default:  state_d = WSU_IDLE;
        endcase
    end

    always_comb begin
        busy              = (state_q != WSU_IDLE);
        done              = (state_q == WSU_DONE);
        bus.wm_write_mode = (state_q == WSU_LOAD) || (state_q == WSU_WAIT);
        bus.s_tready      = (state_q == WSU_LOAD) && (beats_acc < beats_exp);
        emit_en           = (state_q == WSU_LOAD);
    end

    always_comb begin
        err_d = start_acc ? 1'b0 : err;
        if (start_acc && cfg_zero) err_d = 1'b1;
        if (bus.wm_write_complete && (state_q != WSU_WAIT)) err_d = 1'b1;
`ifdef WSU_TLAST_CHECK_EN
        if (accept && (bus.s_tlast != (beats_acc == beats_exp - 27'd1))) err_d = 1'b1;
`endif
    end

`ifndef WSU_TLAST_CHECK_EN
    logic unused_tlast;
    assign unused_tlast = bus.s_tlast;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ci_q      <= '0;
            co_q      <= '0;
            beats_acc <= '0;
            words_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if (start_acc) begin
                ci_q      <= cfg_ci_groups;
                co_q      <= cfg_co_groups;
                beats_acc <= '0;
                words_cnt <= '0;
            end else begin
                if (accept) beats_acc <= beats_acc + 27'd1;
                if (emit)   words_cnt <= words_cnt + 26'd1;
            end
            err <= err_d;
        end
    end

    byte_gearbox_8to9 #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_gearbox (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_acc),
        .in_valid (accept),
        .in_data  (bus.s_tdata),
        .emit_en  (emit_en),
        .emit     (emit),
        .out_data (bus.wm_data_out)
    );

    assign bus.wm_data_valid = emit;
endmodule

// File: tb/tb_weight_stream_unpacker.sv
// Randomized bench for weight_stream_unpacker against a byte-queue reference model.
module tb_weight_stream_unpacker;
    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] cfg_ci_groups;
    logic [9:0] cfg_co_groups;
    logic       busy, done, err;
    int         checks = 0;
    int         errors = 0;
    int         words_seen = 0;
    logic [7:0] model_q[$];
    logic [71:0] exp_word;

    weight_stream_unpacker_if #(.IN_W(64), .OUT_W(72)) bus();

    weight_stream_unpacker #(.IN_W(64), .OUT_W(72)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_ci_groups (cfg_ci_groups),
        .cfg_co_groups (cfg_co_groups),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: a word is due whenever 9 unconsumed bytes exist; it holds the 9 oldest.
    always @(negedge clk) begin
        check("valid", 72'(bus.wm_data_valid), 72'(model_q.size() >= 9));
        if (bus.wm_data_valid === 1'b1 && model_q.size() >= 9) begin
            exp_word = '0;
            for (int j = 0; j < 9; j++) exp_word[j*8 +: 8] = model_q.pop_front();
            check("word", bus.wm_data_out, exp_word);
            words_seen++;
        end
        if (rst) model_q.delete();
        else if (bus.s_tvalid && bus.s_tready)
            for (int j = 0; j < 8; j++) model_q.push_back(bus.s_tdata[j*8 +: 8]);
    end

    task automatic start_load(input int ci, input int co);
        start         = 1'b1;
        cfg_ci_groups = 10'(ci);
        cfg_co_groups = 10'(co);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beats(input int n, input int vmode, input bit rnd, input int tlast_at,
                              output int sent);
        int cyc = 0;
        sent = 0;
        while (sent < n && cyc < n * 3 + 20) begin
            bus.s_tvalid = (vmode == 0) ? 1'b1 :
                           (vmode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            bus.s_tlast  = (sent + 1 == tlast_at);
            for (int j = 0; j < 8; j++)
                bus.s_tdata[j*8 +: 8] = rnd ? 8'($urandom) : 8'(sent * 8 + j);
            @(negedge clk);
            if (bus.s_tvalid && bus.s_tready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    task automatic finish_load(input int words_exp, input int base, input logic exp_err);
        int cyc = 0;
        while (words_seen - base < words_exp && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("words", 72'(words_seen - base), 72'(words_exp));
        check("wmode_wait", 72'(bus.wm_write_mode), 72'(1));
        check("busy_wait", 72'(busy), 72'(1));
        bus.wm_write_complete = 1'b1;
        @(posedge clk); #1;
        bus.wm_write_complete = 1'b0;
        check("done_pulse", 72'(done), 72'(1));
        check("wmode_done", 72'(bus.wm_write_mode), 72'(0));
        @(posedge clk); #1;
        check("done_low", 72'(done), 72'(0));
        check("busy_idle", 72'(busy), 72'(0));
        check("err_end", 72'(err), 72'(exp_err));
    endtask

    task automatic run_load(input int ci, input int co, input int vmode, input bit rnd,
                            input int tlast_at, input logic exp_err);
        int n, sent, base;
        n    = ci * co * 72;
        base = words_seen;
        start_load(ci, co);
        check("wmode_load", 72'(bus.wm_write_mode), 72'(1));
        send_beats(n, vmode, rnd, tlast_at, sent);
        check("beats", 72'(sent), 72'(n));
        bus.s_tvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("tready_low", 72'(bus.s_tready), 72'(0));
        end
        @(posedge clk); #1;
        bus.s_tvalid = 1'b0;
        finish_load(ci * co * 64, base, exp_err);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tready"}, 72'(bus.s_tready), 72'(0));
        check({tag, "_wmode"},  72'(bus.wm_write_mode), 72'(0));
        check({tag, "_valid"},  72'(bus.wm_data_valid), 72'(0));
        check({tag, "_data"},   bus.wm_data_out, 72'(0));
        check({tag, "_busy"},   72'(busy), 72'(0));
        check({tag, "_done"},   72'(done), 72'(0));
        check({tag, "_err"},    72'(err), 72'(0));
    endtask

    initial begin
        int   sent;
        logic tlast_err;
`ifdef WSU_TLAST_CHECK_EN
        tlast_err = 1'b1;
`else
        tlast_err = 1'b0;
`endif
        rst = 1'b1;
        start = 1'b0;
        cfg_ci_groups = '0;
        cfg_co_groups = '0;
        bus.s_tdata = '0;
        bus.s_tvalid = 1'b0;
        bus.s_tlast = 1'b0;
        bus.wm_write_complete = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_load(1, 1, 0, 1'b0, 72, 1'b0);
        run_load(1, 1, 1, 1'b0, 72, 1'b0);
        run_load(2, 3, 2, 1'b1, 432, 1'b0);

        // stray completion outside WAIT
        bus.wm_write_complete = 1'b1;
        @(posedge clk); #1;
        bus.wm_write_complete = 1'b0;
        check("stray_err", 72'(err), 72'(1));

        start_load(0, 5);
        check("zero_done", 72'(done), 72'(1));
        check("zero_err", 72'(err), 72'(1));
        check("zero_wmode", 72'(bus.wm_write_mode), 72'(0));
        check("zero_tready", 72'(bus.s_tready), 72'(0));
        @(posedge clk); #1;
        check("zero_done_low", 72'(done), 72'(0));
        check("zero_busy", 72'(busy), 72'(0));
        check("zero_err_sticky", 72'(err), 72'(1));
        check("zero_wmode2", 72'(bus.wm_write_mode), 72'(0));

        run_load(1, 1, 0, 1'b1, 10, tlast_err);

        start_load(1, 1);
        send_beats(20, 0, 1'b1, 0, sent);
        check("beats_pre_rst", 72'(sent), 72'(20));
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_valid", 72'(bus.wm_data_valid), 72'(0));

        run_load(1, 1, 2, 1'b1, 72, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
